// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage of the mini MIPS core: PC, program memory,
// instruction register, halt detection and retired-instruction counter.
module mips_fetch_unit #(
  parameter int          ADDR_W  = 8,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_eq,
  input  logic              branch_not_eq,
  input  logic              alu_zero,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr,
  output logic [3:0]        opcode,
  output logic [2:0]        rs,
  output logic [2:0]        rt,
  output logic [2:0]        rd,
  output logic [5:0]        imm,
  output logic              instr_valid,
  output logic              halted,
  output logic [15:0]       retired
);

  typedef enum logic [1:0] {
    FILL,
    RUN,
    HALT
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = 1;

  state_t            state;
  logic [15:0]       mem [2**ADDR_W];
  logic              take;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] next_pc;

  assign opcode = instr[15:12];
  assign rs     = instr[11:9];
  assign rt     = instr[8:6];
  assign rd     = instr[5:3];
  assign imm    = instr[5:0];

  assign take    = (branch_eq & alu_zero)
                 | (branch_not_eq & ~alu_zero);
  assign offset  = {{(ADDR_W-6){imm[5]}}, imm};
  assign next_pc = take ? pc + ONE + offset
                        : pc + ONE;

  // No reset here: program contents survive a core reset.
  always_ff @(posedge clk) begin
    if (prog_we)
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FILL;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      retired     <= '0;
    end else begin
      unique case (state)
        FILL: begin
          instr       <= mem[0];
          instr_valid <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          if (!stall) begin
            if (opcode == HALT_OP) begin
              state       <= HALT;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
            end else begin
              pc    <= next_pc;
              instr <= mem[next_pc];
              if (retired != 16'hFFFF)
                retired <= retired + 16'd1;
            end
          end
        end
        HALT: begin
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
